// File: rtl/accelerator_pkg.sv
// Shared types for the accelerator data-port memory responder.
//   obi_resp_t     : response payload returned alongside rvalid
//   gnt_state_e    : grant FSM state encoding
//   MEM_WORD_BYTES : bytes per SRAM word / byte-enable lanes
package accelerator_pkg;

    localparam int unsigned MEM_WORD_BYTES = 4;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } obi_resp_t;

    typedef enum logic {
        GNT_IDLE = 1'b0,
        GNT_WAIT = 1'b1
    } gnt_state_e;

endpackage

// File: rtl/mem_resp_pipe.sv
// Fixed-latency response pipeline for data_mem_responder.
// A RESP_LATENCY-deep shift register of {valid, obi_resp_t}; an entry
// loaded at a grant edge appears on out_* RESP_LATENCY cycles later.
// Ports:
//   clk, reset        : clock, synchronous active-high reset (flushes pipe)
//   in_valid, in_resp : response captured at the grant edge
//   out_valid,out_resp: response presented to the initiator
module mem_resp_pipe
    import accelerator_pkg::*;
#(
    parameter int unsigned RESP_LATENCY = 1
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      in_valid,
    input  obi_resp_t in_resp,
    output logic      out_valid,
    output obi_resp_t out_resp
);

    logic [RESP_LATENCY-1:0] valid_q;
    obi_resp_t               resp_q [RESP_LATENCY];

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            for (int unsigned i = 0; i < RESP_LATENCY; i++) begin
                resp_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= in_valid;
            resp_q[0]  <= in_resp;
            for (int unsigned i = 1; i < RESP_LATENCY; i++) begin
                valid_q[i] <= valid_q[i-1];
                resp_q[i]  <= resp_q[i-1];
            end
        end
    end

    assign out_valid = valid_q[RESP_LATENCY-1];
    assign out_resp  = resp_q[RESP_LATENCY-1];

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the accelerator/core data port.
// Serves req/gnt/rvalid transactions from an internal word-addressed SRAM
// with a programmable grant delay, external stall and fixed response latency.
// Ports:
//   clk, reset                    : clock, synchronous active-high reset
//   data_req_i / data_gnt_o       : request handshake (gnt combinational)
//   data_we_i, data_be_i          : write enable, byte enables
//   data_addr_i, data_wdata_i     : byte address, write data
//   data_rvalid_o, data_rdata_o,
//   data_err_o                    : response (one per grant, in order)
//   stall_i                       : forces gnt low
//   bd_we_i, bd_addr_i, bd_wdata_i: backdoor full-word preload
module data_mem_responder
    import accelerator_pkg::*;
#(
    parameter int unsigned DEPTH        = 1024,
    parameter int unsigned GNT_DELAY    = 0,
    parameter int unsigned RESP_LATENCY = 1,
    parameter logic [31:0] BASE_ADDR    = 32'h0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     data_req_i,
    output logic                     data_gnt_o,
    output logic                     data_rvalid_o,
    input  logic                     data_we_i,
    input  logic [3:0]               data_be_i,
    input  logic [31:0]              data_addr_i,
    input  logic [31:0]              data_wdata_i,
    output logic [31:0]              data_rdata_o,
    output logic                     data_err_o,
    input  logic                     stall_i,
    input  logic                     bd_we_i,
    input  logic [$clog2(DEPTH)-1:0] bd_addr_i,
    input  logic [31:0]              bd_wdata_i
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = (GNT_DELAY > 0) ? $clog2(GNT_DELAY + 1) : 1;
    localparam logic [CW-1:0] GNT_CNT_MAX = CW'(GNT_DELAY);

    // Grant FSM
    gnt_state_e    state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic          gnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= GNT_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        gnt     = data_req_i & ~stall_i & (count_q == GNT_CNT_MAX);
        if (!data_req_i || gnt) begin
            state_d = GNT_IDLE;
            count_d = '0;
        end else begin
            state_d = GNT_WAIT;
            // Saturating at GNT_DELAY is what makes a stall hold the count.
            if (count_q != GNT_CNT_MAX) begin
                count_d = count_q + 1'b1;
            end
        end
    end

    assign data_gnt_o = gnt;

    // Address decode
    logic          xfer;
    logic [31:0]   word_off;
    logic          in_range;
    logic [AW-1:0] idx;

    assign xfer     = data_req_i & gnt;
    assign word_off = (data_addr_i - BASE_ADDR) >> 2;
    assign in_range = (data_addr_i >= BASE_ADDR) && (word_off < 32'(DEPTH));
    assign idx      = word_off[AW-1:0];

    // SRAM: not reset. The bus byte writes are issued after the backdoor
    // word write so that on a same-word collision the enabled bus bytes win.
    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (bd_we_i) begin
            mem_q[bd_addr_i] <= bd_wdata_i;
        end
        if (xfer && data_we_i && in_range) begin
            for (int unsigned b = 0; b < MEM_WORD_BYTES; b++) begin
                if (data_be_i[b]) begin
                    mem_q[idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
                end
            end
        end
    end

    // Response capture: read data sampled at the grant edge
    obi_resp_t in_resp, out_resp;

    always_comb begin
        in_resp       = '0;
        in_resp.err   = ~in_range;
        if (!data_we_i && in_range) begin
            in_resp.rdata = mem_q[idx];
        end
    end

    mem_resp_pipe #(
        .RESP_LATENCY(RESP_LATENCY)
    ) u_resp_pipe (
        .clk      (clk),
        .reset    (reset),
        .in_valid (xfer),
        .in_resp  (in_resp),
        .out_valid(data_rvalid_o),
        .out_resp (out_resp)
    );

    assign data_rdata_o = out_resp.rdata;
    assign data_err_o   = out_resp.err;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder.
// Four instances share one stimulus bus; each test observes the instance
// whose parameters it targets:
//   [0] GNT_DELAY=0 LAT=1 BASE=0
//   [1] GNT_DELAY=2 LAT=1 BASE=0
//   [2] GNT_DELAY=0 LAT=3 BASE=0x100
//   [3] GNT_DELAY=0 LAT=2 BASE=0
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        reset, req, we, stall, bd_we;
    logic [3:0]  be;
    logic [31:0] addr, wdata, bd_wdata;
    logic [9:0]  bd_addr;

    logic        gnt    [4];
    logic        rvalid [4];
    logic [31:0] rdata  [4];
    logic        err    [4];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH(1024), .GNT_DELAY(0), .RESP_LATENCY(1), .BASE_ADDR(32'h0)) u_dut0 (
        .clk(clk), .reset(reset), .data_req_i(req), .data_gnt_o(gnt[0]), .data_rvalid_o(rvalid[0]),
        .data_we_i(we), .data_be_i(be), .data_addr_i(addr), .data_wdata_i(wdata),
        .data_rdata_o(rdata[0]), .data_err_o(err[0]), .stall_i(stall),
        .bd_we_i(bd_we), .bd_addr_i(bd_addr), .bd_wdata_i(bd_wdata));

    data_mem_responder #(.DEPTH(1024), .GNT_DELAY(2), .RESP_LATENCY(1), .BASE_ADDR(32'h0)) u_dut1 (
        .clk(clk), .reset(reset), .data_req_i(req), .data_gnt_o(gnt[1]), .data_rvalid_o(rvalid[1]),
        .data_we_i(we), .data_be_i(be), .data_addr_i(addr), .data_wdata_i(wdata),
        .data_rdata_o(rdata[1]), .data_err_o(err[1]), .stall_i(stall),
        .bd_we_i(bd_we), .bd_addr_i(bd_addr), .bd_wdata_i(bd_wdata));

    data_mem_responder #(.DEPTH(1024), .GNT_DELAY(0), .RESP_LATENCY(3), .BASE_ADDR(32'h100)) u_dut2 (
        .clk(clk), .reset(reset), .data_req_i(req), .data_gnt_o(gnt[2]), .data_rvalid_o(rvalid[2]),
        .data_we_i(we), .data_be_i(be), .data_addr_i(addr), .data_wdata_i(wdata),
        .data_rdata_o(rdata[2]), .data_err_o(err[2]), .stall_i(stall),
        .bd_we_i(bd_we), .bd_addr_i(bd_addr), .bd_wdata_i(bd_wdata));

    data_mem_responder #(.DEPTH(1024), .GNT_DELAY(0), .RESP_LATENCY(2), .BASE_ADDR(32'h0)) u_dut3 (
        .clk(clk), .reset(reset), .data_req_i(req), .data_gnt_o(gnt[3]), .data_rvalid_o(rvalid[3]),
        .data_we_i(we), .data_be_i(be), .data_addr_i(addr), .data_wdata_i(wdata),
        .data_rdata_o(rdata[3]), .data_err_o(err[3]), .stall_i(stall),
        .bd_we_i(bd_we), .bd_addr_i(bd_addr), .bd_wdata_i(bd_wdata));

    // Stimulus-only helpers; every task starts and ends 1 time unit after a rising edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic bd_write(input logic [9:0] w, input logic [31:0] d);
        bd_we    = 1'b1;
        bd_addr  = w;
        bd_wdata = d;
        next_cycle();
        bd_we    = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (gnt[k] !== 1'b0 || rvalid[k] !== 1'b0 || rdata[k] !== 32'h0 || err[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset_state[%0d]: got gnt=%b rvalid=%b rdata=%h err=%b, expected all 0",
                         k, gnt[k], rvalid[k], rdata[k], err[k]);
            end
        end
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (rvalid[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_rvalid: got %b expected 0", rvalid[0]);
        end
        next_cycle();
    endtask

    task automatic test_read();
        bd_write(10'd5, 32'hDEADBEEF);
        req = 1'b1; we = 1'b0; addr = 32'h14;
        @(negedge clk);
        checks++;
        if (gnt[0] !== 1'b1) begin
            errors++;
            $display("FAIL read_gnt: got %b expected 1", gnt[0]);
        end
        next_cycle();
        req = 1'b0;
        @(negedge clk);
        checks++;
        if (rvalid[0] !== 1'b1 || rdata[0] !== 32'hDEADBEEF || err[0] !== 1'b0) begin
            errors++;
            $display("FAIL read_resp: got rvalid=%b rdata=%h err=%b expected 1/deadbeef/0",
                     rvalid[0], rdata[0], err[0]);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (rvalid[0] !== 1'b0) begin
            errors++;
            $display("FAIL read_single_rvalid: got %b expected 0", rvalid[0]);
        end
        next_cycle();
    endtask

    task automatic test_byte_write();
        bd_write(10'd2, 32'hAAAAAAAA);
        req = 1'b1; we = 1'b1; be = 4'b0101; addr = 32'h8; wdata = 32'h11223344;
        @(negedge clk);
        checks++;
        if (gnt[0] !== 1'b1) begin
            errors++;
            $display("FAIL write_gnt: got %b expected 1", gnt[0]);
        end
        next_cycle();
        req = 1'b0; we = 1'b0;
        @(negedge clk);
        checks++;
        if (rvalid[0] !== 1'b1 || rdata[0] !== 32'h0 || err[0] !== 1'b0) begin
            errors++;
            $display("FAIL write_resp: got rvalid=%b rdata=%h err=%b expected 1/00000000/0",
                     rvalid[0], rdata[0], err[0]);
        end
        next_cycle();
        req = 1'b1; addr = 32'h8;
        next_cycle();
        req = 1'b0;
        @(negedge clk);
        checks++;
        if (rvalid[0] !== 1'b1 || rdata[0] !== 32'hAA22AA44) begin
            errors++;
            $display("FAIL byte_write_readback: got rvalid=%b rdata=%h expected 1/aa22aa44", rvalid[0], rdata[0]);
        end
        next_cycle();
    endtask

    task automatic test_backdoor_collision();
        bd_write(10'd3, 32'h11111111);
        bd_we = 1'b1; bd_addr = 10'd3; bd_wdata = 32'hCCCCCCCC;
        req = 1'b1; we = 1'b1; be = 4'b0011; addr = 32'hC; wdata = 32'h00005555;
        next_cycle();
        bd_we = 1'b0; we = 1'b0; addr = 32'hC;
        next_cycle();
        req = 1'b0;
        next_cycle();
        @(negedge clk);
        checks++;
        if (rdata[3] !== 32'hCCCC5555) begin
            errors++;
            $display("FAIL backdoor_collision: got %h expected cccc5555", rdata[3]);
        end
        next_cycle();
    endtask

    task automatic test_gnt_delay();
        int nvalid;
        logic [31:0] got;
        req = 1'b1; we = 1'b0;
        for (int c = 0; c < 5; c++) begin
            stall = (c == 2 || c == 3);
            addr  = (c == 4) ? 32'h14 : 32'h8;
            @(negedge clk);
            checks++;
            if (gnt[1] !== (c == 4)) begin
                errors++;
                $display("FAIL gnt_delay_cycle%0d: got %b expected %b", c, gnt[1], (c == 4));
            end
            next_cycle();
        end
        req = 1'b0; stall = 1'b0;
        nvalid = 0;
        got = '0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (rvalid[1] === 1'b1) begin
                nvalid++;
                got = rdata[1];
            end
        end
        checks++;
        if (nvalid !== 1 || got !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL gnt_delay_resp: got %0d rvalids rdata=%h expected 1 rvalid deadbeef", nvalid, got);
        end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            bd_write(10'(i), 32'hB0B00000 + 32'(i));
        end
        we = 1'b0;
        for (int c = 0; c < 13; c++) begin
            req  = (c < 8);
            addr = 32'h100 + 32'(4 * c);
            @(negedge clk);
            if (c < 8) begin
                checks++;
                if (gnt[2] !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_gnt%0d: got %b expected 1", c, gnt[2]);
                end
            end
            checks++;
            if (rvalid[2] !== (c >= 3 && c < 11)) begin
                errors++;
                $display("FAIL b2b_rvalid_cycle%0d: got %b expected %b", c, rvalid[2], (c >= 3 && c < 11));
            end
            if (c >= 3 && c < 11) begin
                checks++;
                if (rdata[2] !== 32'hB0B00000 + 32'(c - 3)) begin
                    errors++;
                    $display("FAIL b2b_rdata%0d: got %h expected %h", c - 3, rdata[2], 32'hB0B00000 + 32'(c - 3));
                end
            end
            next_cycle();
        end
        req = 1'b0;
    endtask

    task automatic test_out_of_range();
        req = 1'b1; we = 1'b0; addr = 32'h1000;
        next_cycle();
        req = 1'b0;
        @(negedge clk);
        checks++;
        if (rvalid[0] !== 1'b1 || err[0] !== 1'b1 || rdata[0] !== 32'h0) begin
            errors++;
            $display("FAIL oor_read: got rvalid=%b err=%b rdata=%h expected 1/1/00000000", rvalid[0], err[0], rdata[0]);
        end
        next_cycle();
        req = 1'b1; we = 1'b1; be = 4'b1111; addr = 32'h1000; wdata = 32'h12345678;
        next_cycle();
        req = 1'b0; we = 1'b0;
        @(negedge clk);
        checks++;
        if (rvalid[0] !== 1'b1 || err[0] !== 1'b1 || rdata[0] !== 32'h0) begin
            errors++;
            $display("FAIL oor_write_resp: got rvalid=%b err=%b rdata=%h expected 1/1/00000000", rvalid[0], err[0], rdata[0]);
        end
        next_cycle();
        req = 1'b1; addr = 32'h0;
        next_cycle();
        req = 1'b0;
        @(negedge clk);
        checks++;
        if (rdata[0] !== 32'hB0B00000 || err[0] !== 1'b0) begin
            errors++;
            $display("FAIL oor_write_dropped: got word0=%h err=%b expected b0b00000/0", rdata[0], err[0]);
        end
        next_cycle();
        // Below BASE_ADDR on the offset instance
        req = 1'b1; addr = 32'hFC;
        next_cycle();
        req = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (rvalid[2] !== 1'b1 || err[2] !== 1'b1 || rdata[2] !== 32'h0) begin
            errors++;
            $display("FAIL below_base: got rvalid=%b err=%b rdata=%h expected 1/1/00000000", rvalid[2], err[2], rdata[2]);
        end
        next_cycle();
    endtask

    task automatic test_reset_midflight();
        req = 1'b1; we = 1'b0; addr = 32'h14;
        @(negedge clk);
        checks++;
        if (gnt[3] !== 1'b1) begin
            errors++;
            $display("FAIL midflight_gnt: got %b expected 1", gnt[3]);
        end
        next_cycle();
        req = 1'b0; reset = 1'b1;
        for (int c = 1; c < 6; c++) begin
            @(negedge clk);
            checks++;
            if (rvalid[3] !== 1'b0 || gnt[3] !== 1'b0) begin
                errors++;
                $display("FAIL midflight_cycle%0d: got rvalid=%b gnt=%b expected 0/0", c, rvalid[3], gnt[3]);
            end
            next_cycle();
            if (c == 2) reset = 1'b0;
        end
        req = 1'b1; addr = 32'h14;
        next_cycle();
        req = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (rvalid[3] !== 1'b1 || rdata[3] !== 32'hB0B00005) begin
            errors++;
            $display("FAIL post_reset_read: got rvalid=%b rdata=%h expected 1/b0b00005", rvalid[3], rdata[3]);
        end
        next_cycle();
    endtask

    initial begin
        reset = 1'b1; req = 1'b0; we = 1'b0; stall = 1'b0; bd_we = 1'b0;
        be = 4'h0; addr = '0; wdata = '0; bd_wdata = '0; bd_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_read();
        test_byte_write();
        test_backdoor_collision();
        test_gnt_delay();
        test_back_to_back();
        test_out_of_range();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
